// File: rtl/gpio_port.sv
// Parametrised J1 I/O-bus GPIO port: output data, direction, synchronised read-back.
// Optional sticky edge flags with irq summary when GPIO_EDGE_EN is defined.
module gpio_port #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DATA_BIT = 0,
  parameter int unsigned      DIR_BIT  = 1,
  parameter int unsigned      EDGE_BIT = 4,
  parameter logic [WIDTH-1:0] OUT_INIT = '0
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      dout,
  output logic [15:0]      io_din,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic             rd_q, wr_q;
  logic [15:0]      addr_q, dout_q;
  logic [WIDTH-1:0] out_r, dir_r;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] wdata;
  logic             sel_data, sel_dir;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= io_rd;
      wr_q   <= io_wr;
      dout_q <= dout;
      if (io_rd || io_wr)
        addr_q <= mem_addr;
    end
  end

  assign sel_data = addr_q[DATA_BIT];
  assign sel_dir  = addr_q[DIR_BIT];
  assign wdata    = dout_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_r <= OUT_INIT;
      dir_r <= '0;
    end else if (wr_q) begin
      if (sel_data) out_r <= wdata;
      if (sel_dir)  dir_r <= wdata;
    end
  end

  assign pin_out = out_r;
  assign pin_oe  = dir_r;

  // Two-flop synchroniser; pin_in is asynchronous to clk.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

`ifdef GPIO_EDGE_EN
  logic [1:0]       arm;
  logic [WIDTH-1:0] s3, flags, edge_set, flag_clr;
  logic             sel_edge;

  assign sel_edge = addr_q[EDGE_BIT];

  // Arm counter masks the synchroniser fill after reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s3  <= '0;
      arm <= 2'd0;
    end else begin
      s3 <= s2;
      if (arm != 2'd3)
        arm <= arm + 2'd1;
    end
  end

  assign edge_set = (arm == 2'd3) ? ((s2 ^ s3) & ~dir_r) : '0;
  assign flag_clr = (wr_q && sel_edge) ? wdata : '0;

  // Set is ORed in after the clear so a colliding edge wins.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)
      flags <= '0;
    else
      flags <= (flags & ~flag_clr) | edge_set;
  end

  assign irq = |flags;
`else
  assign irq = 1'b0;
`endif

  logic [WIDTH-1:0] rd_val;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    if (rd_q) begin
      if (sel_data) rd_val = rd_val | s2;
      if (sel_dir)  rd_val = rd_val | dir_r;
`ifdef GPIO_EDGE_EN
      if (sel_edge) rd_val = rd_val | flags;
`endif
    end
    io_din = '0;
    io_din[WIDTH-1:0] = rd_val;
  end

  // Only the decoded address bits and low data bits are consumed.
  logic unused_ok;
  assign unused_ok = ^{addr_q, dout_q};

endmodule

// File: tb/tb_gpio_port.sv
// Scoreboard bench for gpio_port (WIDTH=8, OUT_INIT=8'hA5); edge expectations follow GPIO_EDGE_EN.
module tb_gpio_port;

  localparam int unsigned W    = 8;
  localparam logic [7:0]  INIT = 8'hA5;
`ifdef GPIO_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetq;
  logic         io_rd, io_wr;
  logic [15:0]  mem_addr, dout, io_din;
  logic [W-1:0] pin_in, pin_out, pin_oe;
  logic         irq;

  gpio_port #(
    .WIDTH(W), .DATA_BIT(0), .DIR_BIT(1), .EDGE_BIT(4), .OUT_INIT(INIT)
  ) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .mem_addr(mem_addr), .dout(dout), .io_din(io_din),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef enum int {OBS_DIN, OBS_OUT, OBS_OE, OBS_IRQ} obs_e;
  typedef struct {
    string       tag;
    obs_e        sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input obs_e s);
    case (s)
      OBS_DIN: return io_din;
      OBS_OUT: return {8'h00, pin_out};
      OBS_OE:  return {8'h00, pin_oe};
      default: return {15'h0, irq};
    endcase
  endfunction

  task automatic push(input string tag, input obs_e sig, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  function automatic logic [15:0] edge_exp(input logic [15:0] v);
    return EDGE_ON ? v : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Returns in the cycle after the write strobe (wr_q high).
  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    mem_addr = addr; dout = data; io_wr = 1'b1;
    tick();
    io_wr = 1'b0; mem_addr = '0; dout = '0;
  endtask

  // Returns in the cycle where io_din carries the read data.
  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    mem_addr = addr; io_rd = 1'b1;
    tick();
    io_rd = 1'b0; mem_addr = '0;
    push(tag, OBS_DIN, exp);
    drain();
  endtask

  initial begin
    resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    mem_addr = '0; dout = '0; pin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    push("rst_din", OBS_DIN, 16'h0000);
    push("rst_oe",  OBS_OE,  16'h0000);
    push("rst_out", OBS_OUT, {8'h00, INIT});
    push("rst_irq", OBS_IRQ, 16'h0000);
    drain();
    resetq = 1'b1;
    idle(2);

    // DIR write, latency, back-to-back DIR read
    wr(16'h0002, 16'h00FF);
    push("oe_latency", OBS_OE, 16'h0000);
    drain();
    rd(16'h0002, 16'h00FF, "dir_rd_b2b");
    push("dir_oe",   OBS_OE,  16'h00FF);
    push("out_init", OBS_OUT, {8'h00, INIT});
    drain();
    tick();
    push("rd_one_cycle", OBS_DIN, 16'h0000);
    drain();
    wr(16'h0002, 16'h0000);
    tick();

    // Input read-back, unmapped read
    pin_in = 8'h3C;
    idle(3);
    rd(16'h0001, 16'h003C, "data_rd");
    tick();
    push("data_rd_one", OBS_DIN, 16'h0000);
    drain();
    rd(16'h0010, edge_exp(16'h003C), "edge_rd_multi");
    wr(16'h0010, 16'h00FF);
    tick();
    push("w1c_all", OBS_IRQ, 16'h0000);
    drain();
    rd(16'h0008, 16'h0000, "unmapped");

    // Single rising edge on pin 2
    pin_in = 8'h00;
    idle(4);
    wr(16'h0010, 16'h00FF);
    tick();
    push("irq_clear0", OBS_IRQ, 16'h0000);
    drain();
    pin_in = 8'h04;
    tick();
    tick();
    push("irq_early", OBS_IRQ, 16'h0000);
    drain();
    tick();
    push("irq_edge", OBS_IRQ, edge_exp(16'h0001));
    drain();
    rd(16'h0010, edge_exp(16'h0004), "edge_rd");
    rd(16'h0010, edge_exp(16'h0004), "edge_rd_sticky");
    wr(16'h0010, 16'h0004);
    tick();
    push("w1c_bit2", OBS_IRQ, 16'h0000);
    drain();

    // Edge and W1C on bit 2 at the same edge: set wins
    pin_in = 8'h00;
    tick();
    wr(16'h0010, 16'h0004);
    tick();
    push("collision", OBS_IRQ, edge_exp(16'h0001));
    drain();
    rd(16'h0010, edge_exp(16'h0004), "collision_rd");
    idle(2);
    wr(16'h0010, 16'h00FF);
    tick();
    push("clear_all", OBS_IRQ, 16'h0000);
    drain();

    // Edge on an output pin is not captured
    wr(16'h0002, 16'h0020);
    tick();
    pin_in = 8'h20;
    idle(4);
    push("out_pin_irq", OBS_IRQ, 16'h0000);
    drain();
    rd(16'h0010, 16'h0000, "out_pin_edge_rd");

    // Multi-select write and read
    wr(16'h0003, 16'hFFFF);
    tick();
    push("multi_out", OBS_OUT, 16'h00FF);
    push("multi_oe",  OBS_OE,  16'h00FF);
    drain();
    rd(16'h0003, 16'h00FF, "multi_rd");

    // Reset while wr_q is pending, pins held high through release
    mem_addr = 16'h0001; dout = 16'h000F; io_wr = 1'b1;
    tick();
    io_wr = 1'b0; mem_addr = '0; dout = '0;
    resetq = 1'b0;
    pin_in = 8'hFF;
    tick();
    tick();
    push("midrst_out", OBS_OUT, {8'h00, INIT});
    push("midrst_oe",  OBS_OE,  16'h0000);
    push("midrst_irq", OBS_IRQ, 16'h0000);
    drain();
    resetq = 1'b1;
    idle(8);
    push("arm_irq",  OBS_IRQ, 16'h0000);
    push("arm_out",  OBS_OUT, {8'h00, INIT});
    drain();
    rd(16'h0010, 16'h0000, "arm_edge_rd");
    rd(16'h0001, 16'h00FF, "post_rst_data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port on the J1 I/O bus, replacing the fixed 8-bit PMOD/LED/misc registers in the board top level. It provides per-pin output data, per-pin direction, synchronised input read-back, and optional sticky edge-capture flags with an interrupt-style summary output. It decodes one-hot `mem_addr` bits, so several instances can be ORed onto `io_din`. Each instance drives `SB_IO` tristate pads through `pin_out`/`pin_oe`.

## Interface
Parameters:
- `WIDTH`, 8: number of pins, 1..16.
- `DATA_BIT`, 0: one-hot `mem_addr` bit selecting the DATA register.
- `DIR_BIT`, 1: one-hot `mem_addr` bit selecting the DIR register.
- `EDGE_BIT`, 4: one-hot `mem_addr` bit selecting the EDGE register.
- `OUT_INIT`, 0: reset value of the output data register, WIDTH bits.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `resetq` in 1: asynchronous, active-low reset.
- `io_rd` in 1: J1 I/O read strobe.
- `io_wr` in 1: J1 I/O write strobe.
- `mem_addr` in 16: J1 I/O address. Decoded one-hot.
- `dout` in 16: J1 write data.
- `io_din` out 16: read data. Zero when this port is not being read.
- `pin_in` in WIDTH: pad input values. Asynchronous to `clk`.
- `pin_out` out WIDTH: pad output values.
- `pin_oe` out WIDTH: pad output enables. 1 = drive.
- `irq` out 1: OR of all edge flags.

## Operation
- **Bus capture.** Each cycle the block registers `rd_q<=io_rd`, `wr_q<=io_wr` and `dout_q<=dout`. It loads `addr_q<=mem_addr` only when `io_rd|io_wr`.
- **Writes.** When `wr_q` is high, every selected register takes `dout_q[WIDTH-1:0]`. If several select bits are set, all selected registers update in the same cycle. Upper `dout` bits are ignored.
  - DATA write: `out_r`.
  - DIR write: `dir_r`.
  - EDGE write: write-1-to-clear of `flags`.
- **Pin outputs.** `pin_out=out_r` and `pin_oe=dir_r`.
- **Input synchroniser.** `pin_in` passes through two flops, `s1` then `s2`. A third flop `s3<=s2` is used for edge detection.
- **Reads.** `io_din` is combinational from `addr_q`, gated by `rd_q`. When several bits are selected, their read values are ORed. Bits above WIDTH read 0.
  - DATA read: `{0, s2}`.
  - DIR read: `{0, dir_r}`.
  - EDGE read: `{0, flags}`.
  - Nothing selected, or `rd_q` low: `io_din=0`.
- **Edge capture.** `flags[i]` is set when `s2[i]^s3[i]` and `dir_r[i]==0`. Edges on output pins are not captured.
- **Arming.** A 2-bit arm counter counts from 0 after reset and saturates at 3. Flags cannot be set until it reaches 3, which suppresses spurious edges while the synchroniser fills.
- **Set/clear collision.** If an edge and a W1C hit the same bit in the same cycle, the set wins.
- `irq=|flags`.

## Timing
- **Reset values.**
  - `out_r=OUT_INIT`, `dir_r=0` (all pins input), `flags=0`.
  - `s1`, `s2`, `s3`, `arm` all 0.
  - `rd_q`, `wr_q`, `addr_q`, `dout_q` all 0.
  - Resulting outputs: `io_din=0`, `pin_oe=0`, `irq=0`.
- **Reset mid-transfer.** A pending `wr_q` is discarded.
- **Write latency.** `io_wr` high in cycle t means the register updates at edge t+1, so `pin_out`/`pin_oe` change in cycle t+2.
- **Read latency.** `io_rd` in cycle t means `io_din` is valid during cycle t+1 only, matching the J1 one-cycle I/O read.
- **Back-to-back.** Accesses in consecutive cycles are supported. A read of DIR in the cycle after a DIR write returns the new value.
- **Input latency.** A pin change sampled into `s1` at edge k is readable via DATA from cycle k+1 (in `s2`). Its flag is set at edge k+2 and `irq` is high from cycle k+2.
- **Armed window.** The first edge able to set a flag is the 4th clock edge after `resetq` rises.
- **Read vs. set.** Reading EDGE does not clear flags. An edge arriving during the read cycle is retained.

## Configuration
- `GPIO_EDGE_EN` defined: edge capture, the arm counter, `flags` and `irq` are implemented as above.
- `GPIO_EDGE_EN` undefined: none of that logic exists. `irq` is tied to 0, EDGE reads return 0, and EDGE writes are ignored. DATA and DIR behaviour is unchanged, as is `s3` removal.

## Test plan
- **Reset and DIR/DATA write.** Reset with `OUT_INIT=8'hA5` then write DIR=`16'h00FF` at `mem_addr=16'h0002` → `pin_oe=8'hFF`, `pin_out=8'hA5` two cycles after `io_wr`. A DIR read returns `16'h00FF` in the following cycle.
- **Input read-back and unmapped read.**
  - With DIR=0, drive `pin_in=8'h3C`, wait 3 cycles, read `mem_addr=16'h0001` → `io_din=16'h003C` for exactly one cycle.
  - Read `mem_addr=16'h0008` → `io_din=0`.
- **Edge capture and W1C.**
  - Toggle `pin_in[2]` 0→1 → `flags=8'h04` and `irq=1` two cycles after sampling. An EDGE read returns `16'h0004`.
  - Write `16'h0004` to EDGE → `irq=0`.
  - Collision: toggle `pin_in[2]` in the same cycle as the W1C → flag stays 1.
- **Output pins and arming.**
  - With `dir_r[5]=1`, toggle `pin_in[5]` → no flag set.
  - Hold `pin_in=8'hFF` through reset release → `flags` remains 0.
- **Multi-select and mid-transfer reset.**
  - Write `16'hFFFF` to `mem_addr=16'h0003` → DATA and DIR both become `8'hFF`.
  - Assert `resetq` low in the cycle after `io_wr` → write lost, `out_r=OUT_INIT`.
- **Build with GPIO_EDGE_EN undefined.** Toggle pins → `irq` stays 0 and EDGE reads return 0.
